// File: rtl/parking_pkg.sv
// Shared types and constants for the parking access scheduler: ID width,
// default widths, FSM state encoding and round-robin grant side.
package parking_pkg;

  localparam int ID_W       = 2;
  localparam int TS_W_DEF   = 8;
  localparam int COST_W_DEF = 12;

  localparam logic [ID_W-1:0] ID_NONE = '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY_WR  = 3'd1,
    S_ENTRY_REJ = 3'd2,
    S_EXIT_RD   = 3'd3,
    S_EXIT_CALC = 3'd4,
    S_EXIT_DONE = 3'd5,
    S_EXIT_ERR  = 3'd6,
    S_RELEASE   = 3'd7
  } state_t;

  typedef enum logic {
    GRANT_ENTRY = 1'b0,
    GRANT_EXIT  = 1'b1
  } side_t;

endpackage

// File: rtl/parking_fee_calc.sv
// Combinational fee: wrap-safe elapsed ticks times RATE, saturated to the
// largest value representable in COST_W bits.
module parking_fee_calc #(
  parameter int TS_W   = 8,
  parameter int RATE   = 1,
  parameter int COST_W = 12
) (
  input  logic [TS_W-1:0]   ts_now,
  input  logic [TS_W-1:0]   ts_stored,
  output logic [COST_W-1:0] fee
);

  localparam int PROD_W = TS_W + 32;
  localparam logic [PROD_W-1:0] FEE_MAX = PROD_W'((64'd1 << COST_W) - 64'd1);

  function automatic logic [COST_W-1:0] sat_fee(input logic [PROD_W-1:0] raw);
    if (raw > FEE_MAX) return '1;
    return raw[COST_W-1:0];
  endfunction

  logic [TS_W-1:0]   elapsed;
  logic [PROD_W-1:0] raw_fee;

  // Modular subtraction makes a timer wrap between entry and exit harmless.
  assign elapsed = ts_now - ts_stored;
  assign raw_fee = PROD_W'(elapsed) * PROD_W'(RATE);
  assign fee     = sat_fee(raw_fee);

endmodule

// File: rtl/parking_access_scheduler.sv
// Arbitrates entry/exit gates onto the shared single-port timestamp buffer,
// allocates slot IDs, computes exit fees and tracks occupancy.
module parking_access_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int TS_W      = TS_W_DEF,
  parameter int RATE      = 1,
  parameter int COST_W    = COST_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [ID_W-1:0]      exit_id,
  input  logic [TS_W-1:0]      time_now,
  output logic                 entry_ack,
  output logic [ID_W-1:0]      entry_id,
  output logic                 entry_reject,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic [COST_W-1:0]    fee,
  output logic                 fee_valid,
  output logic                 buf_we,
  output logic                 buf_re,
  output logic [ID_W-1:0]      buf_addr,
  output logic [TS_W-1:0]      buf_wdata,
  input  logic [TS_W-1:0]      buf_rdata,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [1:0]           car_count,
  output logic                 busy
);

  state_t                 state_q;
  side_t                  last_grant_q;
  logic [NUM_SLOTS-1:0]   occupancy_q;
  logic [1:0]             car_count_q;
  logic [COST_W-1:0]      fee_q;
  logic                   entry_ack_q, entry_reject_q, exit_ack_q, exit_err_q;
  logic                   fee_valid_q, buf_we_q, buf_re_q;
  logic [ID_W-1:0]        buf_addr_q;
  logic [TS_W-1:0]        ts_latch_q;
  logic [ID_W-1:0]        id_q;

  logic [ID_W-1:0]        alloc_id_d;
  logic                   grant_d, grant_exit_d, garage_full_d, exit_valid_d;
  logic                   release_done_d;
  logic [3:0]             occ_by_id_d;
  logic [NUM_SLOTS-1:0]   id_mask_d;
  logic [COST_W-1:0]      fee_d;

  // Lowest clear occupancy bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    alloc_id_d = ID_NONE;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy_q[i]) alloc_id_d = ID_W'(i + 1);
    end
  end

  // Bit k of occ_by_id_d is "ID k parked"; bit 0 and bits above NUM_SLOTS read 0,
  // so ID 0 and out-of-range IDs fail the same lookup as free slots.
  assign occ_by_id_d    = 4'({occupancy_q, 1'b0});
  assign exit_valid_d   = occ_by_id_d[exit_id];
  assign garage_full_d  = (car_count_q == 2'(NUM_SLOTS));
  assign grant_d        = (state_q == S_IDLE) && (entry_req || exit_req);
  assign grant_exit_d   = (entry_req && exit_req) ? (last_grant_q == GRANT_ENTRY) : exit_req;
  assign release_done_d = (last_grant_q == GRANT_EXIT) ? !exit_req : !entry_req;
  assign id_mask_d      = NUM_SLOTS'(1) << (id_q - ID_W'(1));

  parking_fee_calc #(
    .TS_W  (TS_W),
    .RATE  (RATE),
    .COST_W(COST_W)
  ) u_fee_calc (
    .ts_now   (ts_latch_q),
    .ts_stored(buf_rdata),
    .fee      (fee_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= GRANT_ENTRY;
      occupancy_q    <= '0;
      car_count_q    <= '0;
      fee_q          <= '0;
      entry_ack_q    <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_ack_q     <= 1'b0;
      exit_err_q     <= 1'b0;
      fee_valid_q    <= 1'b0;
      buf_we_q       <= 1'b0;
      buf_re_q       <= 1'b0;
      buf_addr_q     <= ID_NONE;
    end else begin
      entry_ack_q    <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_ack_q     <= 1'b0;
      exit_err_q     <= 1'b0;
      fee_valid_q    <= 1'b0;
      buf_we_q       <= 1'b0;
      buf_re_q       <= 1'b0;
      buf_addr_q     <= ID_NONE;
      // Outputs are registered: each branch arms the strobes of the state it enters.
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            if (grant_exit_d) begin
              last_grant_q <= GRANT_EXIT;
              if (exit_valid_d) begin
                state_q    <= S_EXIT_RD;
                buf_re_q   <= 1'b1;
                buf_addr_q <= exit_id;
              end else begin
                state_q    <= S_EXIT_ERR;
                exit_err_q <= 1'b1;
              end
            end else begin
              last_grant_q <= GRANT_ENTRY;
              if (garage_full_d) begin
                state_q        <= S_ENTRY_REJ;
                entry_reject_q <= 1'b1;
              end else begin
                state_q     <= S_ENTRY_WR;
                buf_we_q    <= 1'b1;
                buf_addr_q  <= alloc_id_d;
                entry_ack_q <= 1'b1;
              end
            end
          end
        end
        S_ENTRY_WR: begin
          occupancy_q <= occupancy_q | id_mask_d;
          car_count_q <= car_count_q + 2'd1;
          state_q     <= S_RELEASE;
        end
        S_EXIT_RD: begin
          state_q <= S_EXIT_CALC;
        end
        S_EXIT_CALC: begin
          fee_q       <= fee_d;
          exit_ack_q  <= 1'b1;
          fee_valid_q <= 1'b1;
          state_q     <= S_EXIT_DONE;
        end
        S_EXIT_DONE: begin
          occupancy_q <= occupancy_q & ~id_mask_d;
          car_count_q <= car_count_q - 2'd1;
          state_q     <= S_RELEASE;
        end
        S_ENTRY_REJ, S_EXIT_ERR: begin
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          // Hold here until the served gate lets go, so a held level is not re-served.
          if (release_done_d) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Grant-time capture of the timestamp and the ID being served.
  always_ff @(posedge clk) begin
    if (grant_d) begin
      ts_latch_q <= time_now;
      id_q       <= grant_exit_d ? exit_id : alloc_id_d;
    end
  end

  assign entry_ack    = entry_ack_q;
  assign entry_id     = id_q;
  assign entry_reject = entry_reject_q;
  assign exit_ack     = exit_ack_q;
  assign exit_err     = exit_err_q;
  assign fee          = fee_q;
  assign fee_valid    = fee_valid_q;
  assign buf_we       = buf_we_q;
  assign buf_re       = buf_re_q;
  assign buf_addr     = buf_addr_q;
  assign buf_wdata    = ts_latch_q;
  assign occupancy    = occupancy_q;
  assign car_count    = car_count_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_parking_access_scheduler.sv
// Bench for parking_access_scheduler: directed scenarios with literal
// expectations plus a randomized run checked against a transaction-level model.
module tb_parking_access_scheduler;

  localparam int NUM = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        entry_req, exit_req;
  logic [1:0]  exit_id;
  logic [7:0]  time_now;
  logic [7:0]  buf_rdata;

  logic        entry_ack, entry_reject, exit_ack, exit_err, fee_valid;
  logic [1:0]  entry_id, buf_addr, car_count;
  logic [11:0] fee;
  logic        buf_we, buf_re, busy;
  logic [7:0]  buf_wdata;
  logic [2:0]  occupancy;

  logic        s_entry_ack, s_entry_reject, s_exit_ack, s_exit_err, s_fee_valid;
  logic [1:0]  s_entry_id, s_buf_addr, s_car_count;
  logic [11:0] fee_s;
  logic        s_buf_we, s_buf_re, s_busy;
  logic [7:0]  s_buf_wdata;
  logic [2:0]  s_occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parking_access_scheduler #(.NUM_SLOTS(NUM), .TS_W(8), .RATE(1), .COST_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_id(exit_id), .time_now(time_now), .entry_ack(entry_ack), .entry_id(entry_id),
    .entry_reject(entry_reject), .exit_ack(exit_ack), .exit_err(exit_err), .fee(fee),
    .fee_valid(fee_valid), .buf_we(buf_we), .buf_re(buf_re), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .occupancy(occupancy),
    .car_count(car_count), .busy(busy)
  );

  // Same control traffic, RATE=100, to exercise fee saturation.
  parking_access_scheduler #(.NUM_SLOTS(NUM), .TS_W(8), .RATE(100), .COST_W(12)) dut_sat (
    .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
    .exit_id(exit_id), .time_now(time_now), .entry_ack(s_entry_ack), .entry_id(s_entry_id),
    .entry_reject(s_entry_reject), .exit_ack(s_exit_ack), .exit_err(s_exit_err), .fee(fee_s),
    .fee_valid(s_fee_valid), .buf_we(s_buf_we), .buf_re(s_buf_re), .buf_addr(s_buf_addr),
    .buf_wdata(s_buf_wdata), .buf_rdata(buf_rdata), .occupancy(s_occupancy),
    .car_count(s_car_count), .busy(s_busy)
  );

  // Single-port timestamp buffer: read data appears the cycle after buf_re.
  logic [7:0] mem [0:3];
  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    if (buf_re) buf_rdata <= mem[buf_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic ea, erej, xa, xerr, fv, we, re;
    logic [1:0]  addr;
    logic [1:0]  eid;
    logic [7:0]  wdata;
    logic [11:0] fee;
    logic [11:0] fee_sat;
    logic [1:0]  act;   // 1 = park id, 2 = release id
    logic [1:0]  id;
  } rec_t;

  rec_t        m_q[$];
  logic [3:0]  m_occ;        // bit k = ID k parked
  logic [7:0]  m_arr [0:3];
  logic [11:0] m_fee, m_fee_sat;
  int          m_phase;      // 0 idle, 1 serving, 2 waiting for release
  logic        m_last_exit;

  function automatic logic [11:0] model_fee(input logic [7:0] tn, input logic [7:0] ta, input int rate);
    int el, f;
    el = (int'(tn) - int'(ta) + 256) % 256;
    f  = el * rate;
    return (f > 4095) ? 12'd4095 : 12'(f);
  endfunction

  always @(negedge clk) begin
    rec_t r;
    rec_t cur;
    logic gx;
    int   nid;
    cur = '0;
    if (!reset_n) begin
      m_q.delete();
      m_occ = '0; m_fee = '0; m_fee_sat = '0; m_phase = 0; m_last_exit = 1'b0;
    end else if (m_q.size() > 0) begin
      cur = m_q.pop_front();
      if (cur.fv) begin m_fee = cur.fee; m_fee_sat = cur.fee_sat; end
    end

    check("entry_ack",    32'(entry_ack),    32'(cur.ea));
    check("entry_reject", 32'(entry_reject), 32'(cur.erej));
    check("exit_ack",     32'(exit_ack),     32'(cur.xa));
    check("exit_err",     32'(exit_err),     32'(cur.xerr));
    check("fee_valid",    32'(fee_valid),    32'(cur.fv));
    check("buf_we",       32'(buf_we),       32'(cur.we));
    check("buf_re",       32'(buf_re),       32'(cur.re));
    check("buf_addr",     32'(buf_addr),     32'(cur.addr));
    check("occupancy",    32'(occupancy),    32'(m_occ[3:1]));
    check("car_count",    32'(car_count),    32'($countones(m_occ)));
    check("fee",          32'(fee),          32'(m_fee));
    check("fee_sat",      32'(fee_s),        32'(m_fee_sat));
    check("busy",         32'(busy),         32'(m_phase != 0));
    if (cur.ea) check("entry_id", 32'(entry_id), 32'(cur.eid));
    if (cur.we) check("buf_wdata", 32'(buf_wdata), 32'(cur.wdata));

    if (reset_n) begin
      if (cur.act == 2'd1) m_occ[cur.id] = 1'b1;
      if (cur.act == 2'd2) m_occ[cur.id] = 1'b0;
      case (m_phase)
        0: if (entry_req || exit_req) begin
          gx = (entry_req && exit_req) ? !m_last_exit : exit_req;
          m_last_exit = gx;
          m_phase = 1;
          if (gx) begin
            if (exit_id != 0 && int'(exit_id) <= NUM && m_occ[exit_id]) begin
              r = '0; r.re = 1'b1; r.addr = exit_id; m_q.push_back(r);
              r = '0; m_q.push_back(r);
              r = '0; r.xa = 1'b1; r.fv = 1'b1; r.act = 2'd2; r.id = exit_id;
              r.fee     = model_fee(time_now, m_arr[exit_id], 1);
              r.fee_sat = model_fee(time_now, m_arr[exit_id], 100);
              m_q.push_back(r);
            end else begin
              r = '0; r.xerr = 1'b1; m_q.push_back(r);
            end
          end else begin
            nid = 0;
            for (int i = NUM; i >= 1; i--) if (!m_occ[i]) nid = i;
            if (nid == 0) begin
              r = '0; r.erej = 1'b1; m_q.push_back(r);
            end else begin
              m_arr[nid] = time_now;
              r = '0; r.ea = 1'b1; r.eid = 2'(nid); r.we = 1'b1; r.addr = 2'(nid);
              r.wdata = time_now; r.act = 2'd1; r.id = 2'(nid);
              m_q.push_back(r);
            end
          end
        end
        1: if (m_q.size() == 0) m_phase = 2;
        default: if (m_last_exit ? !exit_req : !entry_req) m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got 0 expected 1", nm);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("wait_idle");
  endtask

  task automatic do_entry(input logic [7:0] t, output bit ack, output bit rej,
                          output logic [1:0] id, output logic [7:0] wd);
    bit ok;
    time_now = t; entry_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (entry_ack || entry_reject) begin ok = 1'b1; break; end
    end
    ack = entry_ack; rej = entry_reject; id = entry_id; wd = buf_wdata;
    if (!ok) timeout("entry_service");
  endtask

  task automatic do_exit(input logic [7:0] t, input logic [1:0] id, output bit ack, output bit err,
                         output logic [11:0] f, output logic [11:0] fs, output bit re_ok);
    bit ok;
    time_now = t; exit_id = id; exit_req = 1'b1;
    tick();
    re_ok = buf_re && (buf_addr == id);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (exit_ack || exit_err) begin ok = 1'b1; break; end
      tick();
    end
    ack = exit_ack; err = exit_err; f = fee; fs = fee_s;
    exit_req = 1'b0;
    if (!ok) timeout("exit_service");
    wait_idle();
  endtask

  initial begin
    bit ack, rej, err, re_ok, ok;
    logic [1:0]  id;
    logic [7:0]  wd;
    logic [11:0] f, fs;
    bit e_srv, x_srv;
    int e_dly, x_dly;

    reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_id = '0; time_now = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("reset_occupancy", 32'(occupancy), 0);
    check("reset_car_count", 32'(car_count), 0);
    check("reset_fee", 32'(fee), 0);
    check("reset_busy", 32'(busy), 0);

    // Fill the garage.
    do_entry(8'd10, ack, rej, id, wd); entry_req = 1'b0;
    check("e1_ack", 32'(ack), 1); check("e1_id", 32'(id), 1); check("e1_wdata", 32'(wd), 10);
    wait_idle();
    check("e1_occ", 32'(occupancy), 1); check("e1_count", 32'(car_count), 1);
    do_entry(8'd12, ack, rej, id, wd); entry_req = 1'b0; wait_idle();
    check("e2_id", 32'(id), 2);
    do_entry(8'd14, ack, rej, id, wd); entry_req = 1'b0; wait_idle();
    check("e3_id", 32'(id), 3);
    check("full_occ", 32'(occupancy), 7); check("full_count", 32'(car_count), 3);

    // Full: one reject, busy while request held.
    do_entry(8'd16, ack, rej, id, wd);
    check("full_reject", 32'(rej), 1); check("full_no_ack", 32'(ack), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_busy_held", 32'(busy), 1);
      check("full_single_reject", 32'(entry_reject), 0);
    end
    entry_req = 1'b0; wait_idle();
    check("full_occ_kept", 32'(occupancy), 7);

    do_exit(8'd30, 2'd2, ack, err, f, fs, re_ok);
    check("x2a_fee", 32'(f), 18); check("x2a_occ", 32'(occupancy), 5);
    do_entry(8'd20, ack, rej, id, wd); entry_req = 1'b0; wait_idle();
    check("reuse_id2", 32'(id), 2);
    do_exit(8'd45, 2'd2, ack, err, f, fs, re_ok);
    check("x2_re", 32'(re_ok), 1); check("x2_ack", 32'(ack), 1);
    check("x2_fee", 32'(f), 25); check("x2_fee_sat", 32'(fs), 2500);
    check("x2_occ", 32'(occupancy), 5);

    do_exit(8'd60, 2'd1, ack, err, f, fs, re_ok);
    check("sat_fee", 32'(f), 50); check("sat_fee_sat", 32'(fs), 4095);
    do_entry(8'd250, ack, rej, id, wd); entry_req = 1'b0; wait_idle();
    check("wrap_entry_id", 32'(id), 1);
    do_exit(8'd4, 2'd1, ack, err, f, fs, re_ok);
    check("wrap_fee", 32'(f), 10); check("wrap_fee_sat", 32'(fs), 1000);

    do_exit(8'd70, 2'd0, ack, err, f, fs, re_ok);
    check("id0_err", 32'(err), 1); check("id0_no_re", 32'(re_ok), 0); check("id0_fee_kept", 32'(f), 10);
    do_exit(8'd80, 2'd3, ack, err, f, fs, re_ok);
    check("x3_fee", 32'(f), 66);
    do_exit(8'd81, 2'd3, ack, err, f, fs, re_ok);
    check("unocc_err", 32'(err), 1); check("unocc_no_ack", 32'(ack), 0); check("unocc_fee_kept", 32'(f), 66);

    // First tie after reset goes to exit; entry waits for exit_req to drop.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    time_now = 8'd100; exit_id = 2'd1; entry_req = 1'b1; exit_req = 1'b1;
    tick();
    check("tie_exit_first", 32'(exit_err), 1); check("tie_entry_waits", 32'(entry_ack), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("tie_entry_pending", 32'(entry_ack), 0);
    end
    exit_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (entry_ack) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("tie_entry_served");
    check("tie_entry_id", 32'(entry_id), 1);
    entry_req = 1'b0; wait_idle();

    // Reset in EXIT_CALC aborts the exit.
    time_now = 8'd110; exit_id = 2'd1; exit_req = 1'b1;
    tick();
    check("abort_re", 32'(buf_re), 1);
    tick();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_no_ack", 32'(exit_ack), 0);
    end
    check("abort_occ", 32'(occupancy), 0);
    exit_req = 1'b0; reset_n = 1'b1;
    tick();

    // Randomized traffic honouring the hold-until-served protocol.
    e_srv = 1'b0; x_srv = 1'b0; e_dly = 0; x_dly = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (entry_ack || entry_reject) e_srv = 1'b1;
      if (exit_ack || exit_err) x_srv = 1'b1;
      if (entry_req && e_srv) begin
        if (e_dly == 0) begin entry_req = 1'b0; e_srv = 1'b0; end else e_dly--;
      end else if (!entry_req && ($urandom % 4 == 0)) begin
        entry_req = 1'b1; e_dly = int'($urandom % 3);
      end
      if (exit_req && x_srv) begin
        if (x_dly == 0) begin exit_req = 1'b0; x_srv = 1'b0; end else x_dly--;
      end else if (!exit_req && ($urandom % 4 == 0)) begin
        exit_req = 1'b1; exit_id = 2'($urandom % 4); x_dly = int'($urandom % 3);
      end
      time_now = time_now + 8'($urandom % 4);
      reset_n = ($urandom % 400 != 0);
    end
    reset_n = 1'b1; entry_req = 1'b0; exit_req = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

endmodule
